// File: rtl/col_reduce_pkg.sv
// col_reduce_pkg
// Shared types and constants for the column-reduction stage.
// - red_op_t    : reduction opcode (SUM, MIN, MAX, COUNT)
// - red_state_t : controller state (IDLE, RUN, DONE)
// - DEF_*       : default widths, matching the arithmetic stage
// - data_max / data_min : extreme values of a signed NUM+1 bit element,
//   used as the MIN/MAX accumulator seeds.
package col_reduce_pkg;

   typedef enum logic [1:0] {
      OP_SUM   = 2'd0,
      OP_MIN   = 2'd1,
      OP_MAX   = 2'd2,
      OP_COUNT = 2'd3
   } red_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } red_state_t;

   localparam int DEF_NUM   = 31;
   localparam int DEF_CNT_W = 16;
   localparam int DEF_ACC_W = DEF_NUM + 1 + DEF_CNT_W;

   // Largest positive value of a signed (num+1)-bit element, returned at
   // 64 bits so the caller can size it down to its accumulator width.
   function automatic logic signed [63:0] data_max(input int num);
      return (64'sd1 <<< num) - 64'sd1;
   endfunction

   // Most negative value of a signed (num+1)-bit element.
   function automatic logic signed [63:0] data_min(input int num);
      return -(64'sd1 <<< num);
   endfunction

endpackage

// File: rtl/col_reduce_red_step.sv
// red_step
// Combinational accumulator update for one accepted element.
// Ports:
//   op   - reduction opcode
//   acc  - current accumulator (signed, ACC_W bits)
//   data - incoming element (signed, NUM+1 bits), sign-extended here
//   nxt  - accumulator value after folding in data
import col_reduce_pkg::*;

module red_step #(
   parameter int NUM   = DEF_NUM,
   parameter int ACC_W = DEF_ACC_W
) (
   input  red_op_t                   op,
   input  logic signed [ACC_W-1:0]   acc,
   input  logic signed [NUM:0]       data,
   output logic signed [ACC_W-1:0]   nxt
);

   logic signed [ACC_W-1:0] ext;
   logic signed [ACC_W-1:0] nz;

   assign ext = $signed({{(ACC_W-NUM-1){data[NUM]}}, data});
   assign nz  = $signed({{(ACC_W-1){1'b0}}, (data != '0)});

   // All arithmetic happens at the full accumulator width, so a column of
   // up to 2^CNT_W-1 elements can never overflow the SUM.
   always_comb begin
      nxt = acc + ext;
      case (op)
         OP_MIN:   nxt = (ext < acc) ? ext : acc;
         OP_MAX:   nxt = (ext > acc) ? ext : acc;
         OP_COUNT: nxt = acc + nz;
         default:  nxt = acc + ext;
      endcase
   end

endmodule

// File: rtl/col_reduce.sv
// col_reduce
// Streaming column reduction: folds len signed elements from the arithmetic
// stage into one scalar (SUM, MIN, MAX or COUNT of non-zero) and offers it
// on a ready/valid result port.
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   start, op, len     - launch a reduction (sampled only when idle)
//   in_valid, in_data  - element stream from the arithmetic stage
//   in_ready           - element accepted when high together with in_valid
//   res_valid, res_data, res_empty, res_ready - result handshake
//   busy               - a reduction is running or its result is pending
import col_reduce_pkg::*;

module col_reduce #(
   parameter int NUM   = DEF_NUM,
   parameter int CNT_W = DEF_CNT_W,
   parameter int ACC_W = NUM + 1 + CNT_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  red_op_t                  op,
   input  logic [CNT_W-1:0]         len,
   input  logic                     in_valid,
   input  logic signed [NUM:0]      in_data,
   output logic                     in_ready,
   output logic                     res_valid,
   output logic signed [ACC_W-1:0]  res_data,
   output logic                     res_empty,
   input  logic                     res_ready,
   output logic                     busy
);

   localparam logic signed [ACC_W-1:0] MIN_SEED = ACC_W'(data_max(NUM));
   localparam logic signed [ACC_W-1:0] MAX_SEED = ACC_W'(data_min(NUM));

   red_state_t               state, state_nxt;
   red_op_t                  op_q;
   logic [CNT_W-1:0]         len_q;
   logic [CNT_W-1:0]         cnt;
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  acc_step;
   logic signed [ACC_W-1:0]  acc_seed;
   logic                     empty_q;
   logic                     accept;
   logic                     last_beat;

   red_step #(
      .NUM   (NUM),
      .ACC_W (ACC_W)
   ) u_step (
      .op   (op_q),
      .acc  (acc),
      .data (in_data),
      .nxt  (acc_step)
   );

   assign accept    = in_valid & (state == ST_RUN);
   assign last_beat = accept & (cnt == (len_q - CNT_W'(1)));

   // Seed for the accumulator at start. A zero-length run seeds 0 whatever
   // the opcode, so the DONE state can present acc directly as the result.
   always_comb begin
      acc_seed = '0;
      if (len != '0) begin
         case (op)
            OP_MIN:  acc_seed = MIN_SEED;
            OP_MAX:  acc_seed = MAX_SEED;
            default: acc_seed = '0;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic. start is only honoured in IDLE and res_ready only
   // in DONE, so stray pulses elsewhere have no effect.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start) state_nxt = (len == '0) ? ST_DONE : ST_RUN;
         ST_RUN:  if (last_beat) state_nxt = ST_DONE;
         ST_DONE: if (res_ready) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Datapath: latch the job on start, then fold one element per accepted
   // beat. The last beat's update lands on the same edge that enters DONE,
   // so the final result is visible together with res_valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         op_q    <= OP_SUM;
         len_q   <= '0;
         cnt     <= '0;
         acc     <= '0;
         empty_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  op_q    <= op;
                  len_q   <= len;
                  cnt     <= '0;
                  acc     <= acc_seed;
                  empty_q <= (len == '0);
               end
            end
            ST_RUN: begin
               if (accept) begin
                  acc <= acc_step;
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs are decoded from registered state only.
   always_comb begin
      in_ready  = (state == ST_RUN);
      res_valid = (state == ST_DONE);
      busy      = (state != ST_IDLE);
      res_data  = (state == ST_DONE) ? acc : '0;
      res_empty = (state == ST_DONE) & empty_q;
   end

endmodule
